// File: rtl/rvc_asap_pkg.sv
// Shared D_MEM geometry, dump FSM state type and address helpers for the
// data-memory controller.
package rvc_asap_pkg;

  localparam logic [31:0] D_MEM_OFFSET = 32'h0000_1000;
  localparam int          MSB_D_MEM    = 11;
  localparam int          SIZE_D_MEM   = 2 ** (MSB_D_MEM + 1);
  localparam int          D_MEM_WORDS  = SIZE_D_MEM / 4;
  localparam int          IDX_W        = MSB_D_MEM - 1;
  localparam logic [31:0] D_MEM_END    = D_MEM_OFFSET + 32'(SIZE_D_MEM);

  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(D_MEM_WORDS - 1);
  localparam logic [MSB_D_MEM:0] WORD_MASK = ~((MSB_D_MEM + 1)'(3));

  typedef enum logic [2:0] {
    DUMP_IDLE  = 3'd0,
    DUMP_RD    = 3'd1,
    DUMP_CAP   = 3'd2,
    DUMP_VALID = 3'd3,
    DUMP_DONE  = 3'd4
  } t_dump_st;

  function automatic logic in_dmem(input logic [31:0] addr);
    return (addr >= D_MEM_OFFSET) && (addr < D_MEM_END);
  endfunction

  // Word-aligned byte index inside D_MEM; only meaningful when in_dmem() holds.
  function automatic logic [MSB_D_MEM:0] dmem_index(input logic [31:0] addr);
    return WORD_MASK & (MSB_D_MEM + 1)'(addr - D_MEM_OFFSET);
  endfunction

endpackage

// File: rtl/rvc_dmem_dump.sv
// End-of-test dump engine: walks every D_MEM word (read, capture, present)
// and streams it out over a valid/ready handshake.
module rvc_dmem_dump
  import rvc_asap_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Rst,
  input  logic                 DumpStart,
  input  logic                 DumpReady,
  input  logic [31:0]          MemRdData,
  output logic                 DumpValid,
  output logic [31:0]          DumpAddr,
  output logic [31:0]          DumpData,
  output logic                 DumpDone,
  output logic                 busy,
  output logic                 mem_rd,
  output logic [MSB_D_MEM:0]   mem_addr
);

  t_dump_st         state_r;
  t_dump_st         state_nxt_s;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_nxt_s;
  logic [31:0]      data_r;
  logic             valid_r;
  logic             done_r;

  // Next-state and index sequencing; DumpStart only counts while idle.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      DUMP_IDLE: begin
        if (DumpStart) begin
          state_nxt_s = DUMP_RD;
          idx_nxt_s   = {IDX_W{1'b0}};
        end else begin
          state_nxt_s = DUMP_IDLE;
        end
      end
      DUMP_RD:  state_nxt_s = DUMP_CAP;
      DUMP_CAP: state_nxt_s = DUMP_VALID;
      DUMP_VALID: begin
        if (!DumpReady) begin
          state_nxt_s = DUMP_VALID;
        end else if (idx_r == IDX_LAST) begin
          state_nxt_s = DUMP_DONE;
        end else begin
          state_nxt_s = DUMP_RD;
          idx_nxt_s   = idx_r + IDX_W'(1);
        end
      end
      DUMP_DONE: state_nxt_s = DUMP_IDLE;
      default: begin
        state_nxt_s = DUMP_IDLE;
        idx_nxt_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State, index, captured word and registered stream flags.
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      state_r <= DUMP_IDLE;
      idx_r   <= {IDX_W{1'b0}};
      data_r  <= 32'h0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      valid_r <= (state_nxt_s == DUMP_VALID);
      done_r  <= (state_nxt_s == DUMP_DONE);
      if (state_r == DUMP_CAP) begin
        data_r <= MemRdData;
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign busy      = (state_r != DUMP_IDLE);
  assign mem_rd    = (state_r == DUMP_RD);
  assign mem_addr  = {idx_r, 2'b00};
  assign DumpValid = valid_r;
  assign DumpDone  = done_r;
  assign DumpData  = data_r;
  assign DumpAddr  = D_MEM_OFFSET + 32'({idx_r, 2'b00});

endmodule

// File: rtl/rvc_dmem_ctrl.sv
// Single-port D_MEM arbiter: dump engine > debug port > core, with range
// checking and one-cycle registered read-response qualification.
module rvc_dmem_ctrl
  import rvc_asap_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Rst,
  input  logic                 CoreReq,
  input  logic                 CoreWrEn,
  input  logic [3:0]           CoreByteEn,
  input  logic [31:0]          CoreAddr,
  input  logic [31:0]          CoreWrData,
  output logic                 CoreStall,
  output logic [31:0]          CoreRdData,
  input  logic                 DbgReq,
  input  logic                 DbgWrEn,
  input  logic [31:0]          DbgAddr,
  input  logic [31:0]          DbgWrData,
  output logic                 DbgGnt,
  output logic                 DbgRdValid,
  output logic [31:0]          DbgRdData,
  input  logic                 DumpStart,
  output logic                 DumpValid,
  input  logic                 DumpReady,
  output logic [31:0]          DumpAddr,
  output logic [31:0]          DumpData,
  output logic                 DumpDone,
  output logic                 MemEn,
  output logic                 MemWrEn,
  output logic [3:0]           MemByteEn,
  output logic [MSB_D_MEM:0]   MemAddr,
  output logic [31:0]          MemWrData,
  input  logic [31:0]          MemRdData
);

  logic               dump_busy_s;
  logic               dump_rd_s;
  logic [MSB_D_MEM:0] dump_addr_s;
  logic               dbg_acc_s;
  logic               core_acc_s;
  logic               dbg_in_s;
  logic               core_in_s;
  logic               core_rd_r;
  logic               core_oor_r;
  logic               dbg_rd_r;
  logic               dbg_oor_r;

  rvc_dmem_dump u_dump (
    .Clock     (Clock),
    .Rst       (Rst),
    .DumpStart (DumpStart),
    .DumpReady (DumpReady),
    .MemRdData (MemRdData),
    .DumpValid (DumpValid),
    .DumpAddr  (DumpAddr),
    .DumpData  (DumpData),
    .DumpDone  (DumpDone),
    .busy      (dump_busy_s),
    .mem_rd    (dump_rd_s),
    .mem_addr  (dump_addr_s)
  );

  assign dbg_in_s  = in_dmem(DbgAddr);
  assign core_in_s = in_dmem(CoreAddr);

  // Fixed-priority acceptance; nothing is granted while reset is asserted.
  always_comb begin
    dbg_acc_s  = 1'b0;
    core_acc_s = 1'b0;
    if (Rst && !dump_busy_s) begin
      dbg_acc_s  = DbgReq;
      core_acc_s = CoreReq && !DbgReq;
    end else begin
      dbg_acc_s  = 1'b0;
      core_acc_s = 1'b0;
    end
  end

  assign DbgGnt    = dbg_acc_s;
  assign CoreStall = CoreReq && Rst && (dump_busy_s || DbgReq);

  // Memory port mux; out-of-range accesses never reach the array.
  always_comb begin
    MemEn     = 1'b0;
    MemWrEn   = 1'b0;
    MemByteEn = 4'h0;
    MemAddr   = {(MSB_D_MEM + 1){1'b0}};
    MemWrData = 32'h0;
    if (Rst && dump_busy_s) begin
      MemEn     = dump_rd_s;
      MemByteEn = 4'hF;
      MemAddr   = dump_addr_s;
    end else if (dbg_acc_s) begin
      MemEn     = dbg_in_s;
      MemWrEn   = DbgWrEn && dbg_in_s;
      MemByteEn = 4'hF;
      MemAddr   = dmem_index(DbgAddr);
      MemWrData = DbgWrData;
    end else if (core_acc_s) begin
      MemEn     = core_in_s;
      MemWrEn   = CoreWrEn && core_in_s;
      MemByteEn = CoreByteEn;
      MemAddr   = dmem_index(CoreAddr);
      MemWrData = CoreWrData;
    end else begin
      MemEn = 1'b0;
    end
  end

  // Per-requester read-in-flight and out-of-range flags for the response cycle.
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      core_rd_r  <= 1'b0;
      core_oor_r <= 1'b0;
      dbg_rd_r   <= 1'b0;
      dbg_oor_r  <= 1'b0;
    end else begin
      core_rd_r  <= core_acc_s && !CoreWrEn;
      core_oor_r <= !core_in_s;
      dbg_rd_r   <= dbg_acc_s && !DbgWrEn;
      dbg_oor_r  <= !dbg_in_s;
    end
  end

  assign CoreRdData = (core_rd_r && !core_oor_r) ? MemRdData : 32'h0;
  assign DbgRdValid = dbg_rd_r;
  assign DbgRdData  = (dbg_rd_r && !dbg_oor_r) ? MemRdData : 32'h0;

endmodule

// File: tb/tb_rvc_dmem_ctrl.sv
// Self-checking bench for rvc_dmem_ctrl: directed steps plus randomized
// core/debug traffic checked against a word-array model of D_MEM.
module tb_rvc_dmem_ctrl;

  logic        Clock = 1'b0;
  logic        Rst = 1'b0;
  logic        CoreReq = 1'b0, CoreWrEn = 1'b0;
  logic [3:0]  CoreByteEn = 4'h0;
  logic [31:0] CoreAddr = 32'h0, CoreWrData = 32'h0;
  logic        CoreStall;
  logic [31:0] CoreRdData;
  logic        DbgReq = 1'b0, DbgWrEn = 1'b0;
  logic [31:0] DbgAddr = 32'h0, DbgWrData = 32'h0;
  logic        DbgGnt, DbgRdValid;
  logic [31:0] DbgRdData;
  logic        DumpStart = 1'b0, DumpReady = 1'b0;
  logic        DumpValid, DumpDone;
  logic [31:0] DumpAddr, DumpData;
  logic        MemEn, MemWrEn;
  logic [3:0]  MemByteEn;
  logic [11:0] MemAddr;
  logic [31:0] MemWrData;
  logic [31:0] MemRdData = 32'h0;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [31:0] dmem    [1024];
  logic [31:0] ref_mem [1024];

  rvc_dmem_ctrl dut (
    .Clock(Clock), .Rst(Rst),
    .CoreReq(CoreReq), .CoreWrEn(CoreWrEn), .CoreByteEn(CoreByteEn),
    .CoreAddr(CoreAddr), .CoreWrData(CoreWrData),
    .CoreStall(CoreStall), .CoreRdData(CoreRdData),
    .DbgReq(DbgReq), .DbgWrEn(DbgWrEn), .DbgAddr(DbgAddr), .DbgWrData(DbgWrData),
    .DbgGnt(DbgGnt), .DbgRdValid(DbgRdValid), .DbgRdData(DbgRdData),
    .DumpStart(DumpStart), .DumpValid(DumpValid), .DumpReady(DumpReady),
    .DumpAddr(DumpAddr), .DumpData(DumpData), .DumpDone(DumpDone),
    .MemEn(MemEn), .MemWrEn(MemWrEn), .MemByteEn(MemByteEn), .MemAddr(MemAddr),
    .MemWrData(MemWrData), .MemRdData(MemRdData)
  );

  always #5 Clock = ~Clock;

  // Synchronous D_MEM array: byte-enabled write, registered read.
  always @(posedge Clock) begin
    if (MemEn) begin
      if (MemWrEn) begin
        for (int b = 0; b < 4; b++)
          if (MemByteEn[b]) dmem[MemAddr[11:2]][8*b +: 8] <= MemWrData[8*b +: 8];
      end
      MemRdData <= dmem[MemAddr[11:2]];
    end
  end

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= 32'h1000) && (a < 32'h2000);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - 32'h1000) / 4);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return in_rng(a) ? ref_mem[widx(a)] : 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'h1000 - 32'($urandom_range(1, 64));
    if (r == 1) return 32'h2000 + 32'($urandom_range(0, 64));
    if (r < 9)  return 32'h1000 + 32'($urandom_range(0, 63));
    return 32'h1000 + 32'($urandom_range(0, 4095));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic dbg_write(input logic [31:0] a, input logic [31:0] d);
    DbgReq = 1'b1; DbgWrEn = 1'b1; DbgAddr = a; DbgWrData = d;
    @(negedge Clock);
    chk1("dbg_wr_gnt", DbgGnt, 1'b1);
    chk1("dbg_wr_memen", MemEn, in_rng(a));
    if (in_rng(a)) chk("dbg_wr_memaddr", 32'(MemAddr), (a - 32'h1000) & 32'hFFC);
    tick();
    DbgReq = 1'b0; DbgWrEn = 1'b0;
    if (in_rng(a)) ref_mem[widx(a)] = d;
  endtask

  task automatic dbg_read(input logic [31:0] a);
    DbgReq = 1'b1; DbgWrEn = 1'b0; DbgAddr = a;
    @(negedge Clock);
    chk1("dbg_rd_gnt", DbgGnt, 1'b1);
    chk1("dbg_rd_memen", MemEn, in_rng(a));
    tick();
    DbgReq = 1'b0;
    @(negedge Clock);
    chk1("dbg_rd_valid", DbgRdValid, 1'b1);
    chk("dbg_rd_data", DbgRdData, ref_read(a));
    tick();
  endtask

  task automatic core_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    CoreReq = 1'b1; CoreWrEn = 1'b1; CoreAddr = a; CoreByteEn = be; CoreWrData = d;
    @(negedge Clock);
    chk1("core_wr_stall", CoreStall, 1'b0);
    chk1("core_wr_memen", MemEn, in_rng(a));
    chk1("core_wr_memwren", MemWrEn, in_rng(a));
    if (in_rng(a)) chk("core_wr_memaddr", 32'(MemAddr), (a - 32'h1000) & 32'hFFC);
    tick();
    CoreReq = 1'b0; CoreWrEn = 1'b0;
    if (in_rng(a)) ref_mem[widx(a)] = merge(ref_mem[widx(a)], d, be);
  endtask

  task automatic core_read(input logic [31:0] a);
    CoreReq = 1'b1; CoreWrEn = 1'b0; CoreAddr = a; CoreByteEn = 4'hF;
    @(negedge Clock);
    chk1("core_rd_stall", CoreStall, 1'b0);
    chk1("core_rd_memen", MemEn, in_rng(a));
    tick();
    CoreReq = 1'b0;
    @(negedge Clock);
    chk("core_rd_data", CoreRdData, ref_read(a));
    chk1("core_rd_no_dbgvalid", DbgRdValid, 1'b0);
    tick();
  endtask

  task automatic load_index_pattern();
    DbgReq = 1'b1; DbgWrEn = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      DbgAddr = 32'h1000 + 32'(i * 4);
      DbgWrData = 32'(i);
      ref_mem[i] = 32'(i);
      tick();
    end
    DbgReq = 1'b0; DbgWrEn = 1'b0;
  endtask

  // Full dump with DumpReady toggling; rst_beat >= 0 pulls reset while that beat is presented.
  task automatic run_dump(input int rst_beat);
    int beats, dones, first_valid, last_hs, cyc;
    bit stop;
    beats = 0; dones = 0; first_valid = -1; last_hs = -10; stop = 1'b0; cyc = 0;
    CoreReq = 1'b1; CoreWrEn = 1'b0; CoreAddr = 32'h1000;
    DumpStart = 1'b1; DumpReady = 1'b0;
    @(negedge Clock);
    chk1("dump_pre_core_acc", CoreStall, 1'b0);
    while (!stop && cyc < 8000) begin
      tick();
      cyc++;
      DumpStart = 1'b0;
      DumpReady = cyc[0];
      @(negedge Clock);
      if (cyc == 1) chk("dump_overlap_core_rd", CoreRdData, ref_mem[0]);
      if (DumpDone) begin
        dones++;
        chk("dump_done_beats", beats, 32'd1024);
        chk("dump_done_latency", cyc, last_hs + 1);
        stop = 1'b1;
      end
      if (DumpValid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          chk("dump_first_valid", cyc, 32'd3);
        end
        chk1("dump_core_stall", CoreStall, 1'b1);
        chk("dump_addr", DumpAddr, 32'h1000 + 32'(beats * 4));
        chk("dump_data", DumpData, ref_mem[beats]);
        if (beats == rst_beat) begin
          Rst = 1'b0;
          DumpReady = 1'b0;
          stop = 1'b1;
        end else if (DumpReady) begin
          last_hs = cyc;
          beats++;
        end
      end
    end
    chk1("dump_terminated", stop, 1'b1);
    if (rst_beat < 0) begin
      for (int k = 0; k < 5; k++) begin
        tick();
        @(negedge Clock);
        if (DumpDone) dones++;
        chk1("dump_idle_after_done", DumpValid, 1'b0);
      end
      chk("dump_done_count", dones, 32'd1);
    end else begin
      for (int k = 0; k < 2; k++) begin
        tick();
        @(negedge Clock);
        chk1("rst_dump_valid", DumpValid, 1'b0);
        chk1("rst_dump_done", DumpDone, 1'b0);
      end
      tick();
      Rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
        @(negedge Clock);
        chk1("post_rst_valid", DumpValid, 1'b0);
        chk1("post_rst_done", DumpDone, 1'b0);
        chk1("post_rst_stall", CoreStall, 1'b0);
        tick();
      end
    end
    CoreReq = 1'b0;
    tick();
  endtask

  initial begin
    // Reset with every requester active.
    CoreReq = 1'b1; CoreWrEn = 1'b1; CoreByteEn = 4'hF; CoreAddr = 32'h1000; CoreWrData = 32'h1111_1111;
    DbgReq = 1'b1; DbgWrEn = 1'b1; DbgAddr = 32'h1004; DbgWrData = 32'h2222_2222;
    DumpStart = 1'b1; DumpReady = 1'b1; Rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    @(negedge Clock);
    chk1("rst_core_stall", CoreStall, 1'b0);
    chk1("rst_dbg_gnt", DbgGnt, 1'b0);
    chk1("rst_dbg_rdvalid", DbgRdValid, 1'b0);
    chk("rst_dbg_rddata", DbgRdData, 32'h0);
    chk("rst_core_rddata", CoreRdData, 32'h0);
    chk1("rst_dump_valid", DumpValid, 1'b0);
    chk1("rst_dump_done", DumpDone, 1'b0);
    chk("rst_dump_addr", DumpAddr, 32'h1000);
    chk("rst_dump_data", DumpData, 32'h0);
    chk1("rst_mem_en", MemEn, 1'b0);
    chk1("rst_mem_wren", MemWrEn, 1'b0);
    tick();
    CoreReq = 1'b0; CoreWrEn = 1'b0; DbgReq = 1'b0; DbgWrEn = 1'b0;
    DumpStart = 1'b0; DumpReady = 1'b0; Rst = 1'b1;
    tick();
    @(negedge Clock);
    chk1("idle_no_dump", DumpValid, 1'b0);
    tick();

    load_index_pattern();

    // Debug write then core read of the same word.
    dbg_write(32'h1004, 32'hDEAD_BEEF);
    core_read(32'h1004);
    chk("plan_core_rd", ref_mem[1], 32'hDEAD_BEEF);
    // Core byte write merged, read back through debug.
    core_write(32'h1004, 4'b0010, 32'h0000_AB00);
    dbg_read(32'h1004);
    chk("plan_dbg_merge", dmem[1], 32'hDEAD_ABEF);

    // Out-of-range accesses at both edges of the window.
    core_read(32'h0FFC);
    core_write(32'h2000, 4'hF, 32'h1234_5678);
    core_write(32'h0FFF, 4'hF, 32'h8765_4321);
    dbg_read(32'h1000);
    dbg_read(32'h1FFC);
    core_read(32'h1FFC);

    // Simultaneous requests: debug wins, core follows once debug drops.
    CoreReq = 1'b1; CoreWrEn = 1'b0; CoreAddr = 32'h1008;
    DbgReq = 1'b1; DbgWrEn = 1'b0; DbgAddr = 32'h1004;
    @(negedge Clock);
    chk1("both_dbg_gnt", DbgGnt, 1'b1);
    chk1("both_core_stall", CoreStall, 1'b1);
    chk("both_memaddr_dbg", 32'(MemAddr), 32'h4);
    tick();
    DbgReq = 1'b0;
    @(negedge Clock);
    chk1("both_dbg_rdvalid", DbgRdValid, 1'b1);
    chk("both_dbg_rddata", DbgRdData, ref_mem[1]);
    chk1("both_core_unstall", CoreStall, 1'b0);
    tick();
    CoreReq = 1'b0;
    @(negedge Clock);
    chk("both_core_rddata", CoreRdData, ref_mem[2]);
    tick();

    // Randomized mixed traffic against the word-array model.
    for (int n = 0; n < 300; n++) begin
      int unsigned op;
      logic [31:0] a, d;
      op = $urandom_range(0, 3);
      a = rand_addr();
      d = $urandom;
      case (op)
        0: core_read(a);
        1: core_write(a, 4'($urandom_range(0, 15)), d);
        2: dbg_read(a);
        default: dbg_write(a, d);
      endcase
    end

    // Snapshot dump of the index pattern, then a run interrupted by reset.
    load_index_pattern();
    run_dump(-1);
    run_dump(10);
    core_read(32'h1028);
    dbg_read(32'h1FFC);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rvc_dmem_ctrl.md
# rvc_dmem_ctrl

Data-memory controller between the rvc_asap core data port and the D_MEM array in rvc_mem_wrap. It arbitrates single-port access among three requesters: the core, a debug/loader port (replacing backdoor forcing) and an end-of-test dump engine. The dump engine streams the whole D_MEM word-by-word over a valid/ready interface for the memory snapshot. Memory is synchronous: read data returns one cycle after the request.

## Interface
- D_MEM_OFFSET, 'h1000, byte address of D_MEM word 0
- MSB_D_MEM, 11, MSB of D_MEM byte index (size 2**(MSB_D_MEM+1) bytes, 1024 words)

- Clock  in  1  single clock, all state on posedge
- Rst  in  1  reset, synchronous, active-low (Rst==0 at posedge resets)
- CoreReq / CoreWrEn  in  1 / 1  core access request / write
- CoreByteEn  in  4  write byte enables
- CoreAddr / CoreWrData  in  32 / 32  byte address / write data
- CoreStall  out  1  request not accepted this cycle; core holds request
- CoreRdData  out  32  read data, cycle after accepted read
- DbgReq / DbgWrEn  in  1 / 1  debug word request / write (byte enables all 1)
- DbgAddr / DbgWrData  in  32 / 32  byte address / write data
- DbgGnt  out  1  request accepted this cycle
- DbgRdValid / DbgRdData  out  1 / 32  read response, cycle after granted read
- DumpStart  in  1  one-cycle pulse, start snapshot dump
- DumpValid / DumpReady  out / in  1 / 1  dump stream handshake
- DumpAddr / DumpData  out  32 / 32  byte address / word of current beat
- DumpDone  out  1  one-cycle pulse after last beat
- MemEn / MemWrEn  out  1 / 1  memory access / write
- MemByteEn  out  4  byte enables
- MemAddr  out  MSB_D_MEM+1  byte index (word-aligned, low 2 bits 0)
- MemWrData / MemRdData  out / in  32 / 32  write data / read data (valid cycle after MemEn)

## Operation
- Priority: dump engine (when not IDLE) > debug > core. Fixed, no fairness.
- DbgGnt = DbgReq && dump IDLE. CoreStall = CoreReq && (dump not IDLE || DbgReq).
- Accepted access drives MemEn=1; MemAddr = Addr − D_MEM_OFFSET, low 2 bits forced 0.
- Range check: Addr outside [D_MEM_OFFSET, D_MEM_OFFSET+2**(MSB_D_MEM+1)) -> MemEn=0; write dropped; read response 32'h0.
- Read response: registered "read-in-flight" and "out-of-range" flags per requester; next cycle CoreRdData/DbgRdData = flag_oor ? 0 : MemRdData. DbgRdValid=1 exactly that cycle. CoreRdData undefined except in response cycle.
- Dump FSM states: IDLE, RD, CAP, VALID, DONE.
  - IDLE: DumpStart -> RD, index=0. DumpStart in any other state ignored.
  - RD: MemEn=1, MemWrEn=0, MemAddr=index*4 -> CAP.
  - CAP: register MemRdData into DumpData -> VALID.
  - VALID: DumpValid=1, DumpAddr = D_MEM_OFFSET+index*4; hold until DumpReady. On handshake: last index (1023) -> DONE, else index+1 -> RD.
  - DONE: DumpDone=1 -> IDLE.
- Index width MSB_D_MEM−1 bits; no wrap, terminates at last word.
- Core/debug requests are never accepted while dump not IDLE; accesses accepted before DumpStart complete normally (their response cycle overlaps RD without conflict).

## Timing
- Reset values: CoreStall 0, DbgGnt 0, DbgRdValid 0, DbgRdData 0, CoreRdData 0, DumpValid 0, DumpDone 0, DumpAddr D_MEM_OFFSET, DumpData 0, MemEn 0, MemWrEn 0, FSM IDLE, index 0, all in-flight flags 0.
- Grant/stall outputs combinational from same-cycle requests; Mem* outputs combinational from the winner.
- Read latency 1 cycle for core and debug.
- Dump: 3 cycles/word with DumpReady tied 1; first DumpValid 3 cycles after DumpStart; DumpDone 1 cycle after last handshake; full dump 3072+1 cycles.
- Reset mid-dump: FSM IDLE, DumpValid 0 next cycle, no DumpDone; pending responses discarded.
- DumpReady low stalls in VALID indefinitely; DumpData/DumpAddr stable while stalled.

## Structure
- rvc_asap_pkg: D_MEM_OFFSET, MSB_D_MEM, SIZE_D_MEM, typedef enum t_dump_st {DUMP_IDLE, DUMP_RD, DUMP_CAP, DUMP_VALID, DUMP_DONE}.
- Sub-module rvc_dmem_dump: dump FSM, index counter, DumpData register, handshake; exports busy and its memory request. Arbitration, range check and response registers stay in rvc_dmem_ctrl.

## Test plan
- Reset: Rst=0 for 4 cycles with all requests active -> all outputs at reset values, MemEn=0.
- Debug write 'h1004=32'hDEADBEEF, then core read 'h1004 -> CoreRdData=32'hDEADBEEF one cycle after accept.
- Core byte write ByteEn=4'b0010 data 32'h0000AB00 to 'h1004, debug read -> DbgRdData=32'hDEADABEF.
- Simultaneous CoreReq and DbgReq -> DbgGnt=1, CoreStall=1; core accepted next cycle after DbgReq drops.
- Core read 'h0FFC and write 'h2000 -> MemEn=0, CoreRdData=0, memory unchanged.
- DumpStart after loading word i with i, DumpReady toggling 1/0 -> 1024 beats, DumpAddr 'h1000..'h1FFC, DumpData=i, DumpDone once; CoreStall=1 throughout; Rst low at beat 10 in a repeat run -> DumpValid 0, no DumpDone.
